// File: rtl/bch_dec_24_arb.sv
// ---------------------------------------------------------------------------
// bch_dec_24_arb
// Two-channel frame arbiter and sequencer in front of the shared 24-bit BCH
// decoder. Whole frames are granted round-robin to the decoder. A small tag
// FIFO remembers which channel owns each frame in flight, so that the decoded
// stream can be returned with its channel ID. Corrected-error totals are
// accumulated per channel.
//
// Ports
//   clk, reset           : single clock, async active-high reset
//   s0_* / s1_*          : requester frame streams (valid/sop/eop/data/ready)
//   dec_load/sop/eop/data: decoder input handshake, dec_ready back-pressure
//   dec_valid_out/...    : decoder output stream, number_errors on eop
//   dec_sink_ready       : back-pressure towards the decoder output
//   m_*                  : decoded output stream plus owning channel m_chan
//   err_tot0/1           : saturating corrected-error totals per channel
//   drop_cnt             : wrapping count of discarded orphan beats
//   proto_err            : sticky, decoder output seen with no frame in flight
// ---------------------------------------------------------------------------
module bch_dec_24_arb #(
   parameter int TAG_DEPTH = 4,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             s0_valid,
   input  logic             s0_sop,
   input  logic             s0_eop,
   input  logic [23:0]      s0_data,
   output logic             s0_ready,
   input  logic             s1_valid,
   input  logic             s1_sop,
   input  logic             s1_eop,
   input  logic [23:0]      s1_data,
   output logic             s1_ready,
   output logic             dec_load,
   output logic             dec_sop_in,
   output logic             dec_eop_in,
   output logic [23:0]      dec_data_in,
   input  logic             dec_ready,
   input  logic             dec_valid_out,
   input  logic             dec_sop_out,
   input  logic             dec_eop_out,
   input  logic [23:0]      dec_data_out,
   input  logic [7:0]       dec_number_errors,
   output logic             dec_sink_ready,
   output logic             m_valid,
   output logic             m_sop,
   output logic             m_eop,
   output logic [23:0]      m_data,
   output logic             m_chan,
   input  logic             m_ready,
   output logic [7:0]       m_nerr,
   output logic [CNT_W-1:0] err_tot0,
   output logic [CNT_W-1:0] err_tot1,
   output logic [7:0]       drop_cnt,
   output logic             proto_err
);

   localparam int PTR_W = $clog2(TAG_DEPTH);
   localparam int OCC_W = PTR_W + 1;
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
   localparam logic [OCC_W-1:0] OCC_ZERO = OCC_W'(0);
   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(TAG_DEPTH);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } state_t;

   // Saturating accumulate of an 8-bit error count into a CNT_W total.
   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] tot,
                                                input logic [7:0]       inc);
      logic [CNT_W:0] sum;
      sum = {1'b0, tot} + {{(CNT_W-7){1'b0}}, inc};
      if (sum[CNT_W]) begin
         return {CNT_W{1'b1}};
      end else begin
         return sum[CNT_W-1:0];
      end
   endfunction

   state_t           r_state;
   logic             r_gnt;
   logic             r_rr;
   logic             r_tag [0:TAG_DEPTH-1];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [OCC_W-1:0] r_occ;
   logic [CNT_W-1:0] r_err_tot0;
   logic [CNT_W-1:0] r_err_tot1;
   logic [7:0]       r_drop_cnt;
   logic             r_proto_err;

   logic        w_idle;
   logic        w_tag_empty;
   logic        w_tag_full;
   logic        w_cand0;
   logic        w_cand1;
   logic        w_orph0;
   logic        w_orph1;
   logic        w_grant;
   logic        w_gnt_ch;
   logic        w_sel_valid;
   logic        w_sel_sop;
   logic        w_sel_eop;
   logic [23:0] w_sel_data;
   logic        w_acc;
   logic        w_push;
   logic        w_pop;

   assign w_idle      = (r_state == ST_IDLE);
   assign w_tag_empty = (r_occ == OCC_ZERO);
   assign w_tag_full  = (r_occ == OCC_FULL);
   assign w_cand0     = s0_valid & s0_sop;
   assign w_cand1     = s1_valid & s1_sop;
   assign w_orph0     = s0_valid & ~s0_sop;
   assign w_orph1     = s1_valid & ~s1_sop;
   assign w_grant     = w_idle & ~w_tag_full & (w_cand0 | w_cand1);
   // With both channels asking, the priority holder wins; otherwise the only asker.
   assign w_gnt_ch    = (w_cand0 & w_cand1) ? r_rr : w_cand1;

   assign w_sel_valid = r_gnt ? s1_valid : s0_valid;
   assign w_sel_sop   = r_gnt ? s1_sop   : s0_sop;
   assign w_sel_eop   = r_gnt ? s1_eop   : s0_eop;
   assign w_sel_data  = r_gnt ? s1_data  : s0_data;

   assign w_acc  = (r_state == ST_STREAM) & w_sel_valid & dec_ready;
   assign w_push = w_acc & w_sel_eop;
   assign w_pop  = m_valid & m_ready & dec_eop_out;

   // Handshake outputs; all readies and load are forced low while in reset.
   always_comb begin
      s0_ready       = 1'b0;
      s1_ready       = 1'b0;
      dec_load       = 1'b0;
      dec_sink_ready = 1'b0;
      if (reset) begin
         s0_ready       = 1'b0;
         s1_ready       = 1'b0;
         dec_load       = 1'b0;
         dec_sink_ready = 1'b0;
      end else begin
         dec_sink_ready = m_ready | w_tag_empty;
         case (r_state)
            ST_IDLE: begin
               // Orphan beats are swallowed; sop beats wait for the grant.
               s0_ready = w_orph0;
               s1_ready = w_orph1;
            end
            ST_STREAM: begin
               if (r_gnt) begin
                  s1_ready = dec_ready;
               end else begin
                  s0_ready = dec_ready;
               end
               dec_load = w_acc;
            end
            default: begin
               s0_ready = 1'b0;
               s1_ready = 1'b0;
            end
         endcase
      end
   end

   // Data paths: zero-latency pass-through in both directions.
   always_comb begin
      dec_sop_in  = w_sel_sop;
      dec_eop_in  = w_sel_eop;
      dec_data_in = w_sel_data;
      m_valid     = dec_valid_out & ~w_tag_empty;
      m_sop       = dec_sop_out;
      m_eop       = dec_eop_out;
      m_data      = dec_data_out;
      m_nerr      = dec_number_errors;
      m_chan      = r_tag[r_rd_ptr];
      err_tot0    = r_err_tot0;
      err_tot1    = r_err_tot1;
      drop_cnt    = r_drop_cnt;
      proto_err   = r_proto_err;
   end

   // Arbiter FSM: grant in IDLE, stream the granted frame until its eop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_gnt   <= 1'b0;
         r_rr    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_grant) begin
                  r_gnt   <= w_gnt_ch;
                  r_state <= ST_STREAM;
                  if (w_cand0 & w_cand1) begin
                     r_rr <= ~r_rr;
                  end
               end
            end
            ST_STREAM: begin
               if (w_push) begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Tag FIFO: owner channel pushed on input eop, popped on output eop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= {PTR_W{1'b0}};
         r_rd_ptr <= {PTR_W{1'b0}};
         r_occ    <= OCC_ZERO;
         for (int i = 0; i < TAG_DEPTH; i++) begin
            r_tag[i] <= 1'b0;
         end
      end else begin
         if (w_push) begin
            r_tag[r_wr_ptr] <= r_gnt;
            r_wr_ptr        <= r_wr_ptr + PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         case ({w_push, w_pop})
            2'b10:   r_occ <= r_occ + OCC_ONE;
            2'b01:   r_occ <= r_occ - OCC_ONE;
            default: r_occ <= r_occ;
         endcase
      end
   end

   // Statistics: per-channel error totals, orphan drop count, protocol flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_err_tot0  <= {CNT_W{1'b0}};
         r_err_tot1  <= {CNT_W{1'b0}};
         r_drop_cnt  <= 8'd0;
         r_proto_err <= 1'b0;
      end else begin
         if (w_pop) begin
            if (m_chan) begin
               r_err_tot1 <= sat_add(r_err_tot1, dec_number_errors);
            end else begin
               r_err_tot0 <= sat_add(r_err_tot0, dec_number_errors);
            end
         end
         r_drop_cnt <= r_drop_cnt + {7'd0, w_idle & w_orph0}
                                  + {7'd0, w_idle & w_orph1};
         if (dec_valid_out & w_tag_empty) begin
            r_proto_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_bch_dec_24_arb.sv
// Directed self-checking bench for bch_dec_24_arb. The bench plays both the
// requesters and the decoder; every expected value is hand-derived.
module tb_bch_dec_24_arb;

   logic        clk = 1'b0;
   logic        reset;
   logic        s0_valid, s0_sop, s0_eop, s0_ready;
   logic [23:0] s0_data;
   logic        s1_valid, s1_sop, s1_eop, s1_ready;
   logic [23:0] s1_data;
   logic        dec_load, dec_sop_in, dec_eop_in, dec_ready;
   logic [23:0] dec_data_in;
   logic        dec_valid_out, dec_sop_out, dec_eop_out, dec_sink_ready;
   logic [23:0] dec_data_out;
   logic [7:0]  dec_number_errors;
   logic        m_valid, m_sop, m_eop, m_chan, m_ready;
   logic [23:0] m_data;
   logic [7:0]  m_nerr;
   logic [15:0] err_tot0, err_tot1;
   logic [7:0]  drop_cnt;
   logic        proto_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bch_dec_24_arb #(.TAG_DEPTH(4), .CNT_W(16)) dut (
      .clk(clk), .reset(reset),
      .s0_valid(s0_valid), .s0_sop(s0_sop), .s0_eop(s0_eop), .s0_data(s0_data), .s0_ready(s0_ready),
      .s1_valid(s1_valid), .s1_sop(s1_sop), .s1_eop(s1_eop), .s1_data(s1_data), .s1_ready(s1_ready),
      .dec_load(dec_load), .dec_sop_in(dec_sop_in), .dec_eop_in(dec_eop_in), .dec_data_in(dec_data_in),
      .dec_ready(dec_ready), .dec_valid_out(dec_valid_out), .dec_sop_out(dec_sop_out),
      .dec_eop_out(dec_eop_out), .dec_data_out(dec_data_out), .dec_number_errors(dec_number_errors),
      .dec_sink_ready(dec_sink_ready), .m_valid(m_valid), .m_sop(m_sop), .m_eop(m_eop),
      .m_data(m_data), .m_chan(m_chan), .m_ready(m_ready), .m_nerr(m_nerr),
      .err_tot0(err_tot0), .err_tot1(err_tot1), .drop_cnt(drop_cnt), .proto_err(proto_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input int ch, input logic v, input logic sop, input logic eop,
                        input logic [23:0] d);
      if (ch == 0) begin
         s0_valid = v; s0_sop = sop; s0_eop = eop; s0_data = d;
      end else begin
         s1_valid = v; s1_sop = sop; s1_eop = eop; s1_data = d;
      end
   endtask

   function automatic logic rdy(input int ch);
      return (ch == 0) ? s0_ready : s1_ready;
   endfunction

   task automatic idle_inputs();
      drive(0, 1'b0, 1'b0, 1'b0, 24'd0);
      drive(1, 1'b0, 1'b0, 1'b0, 24'd0);
      dec_ready = 1'b1;
      dec_valid_out = 1'b0; dec_sop_out = 1'b0; dec_eop_out = 1'b0;
      dec_data_out = 24'd0; dec_number_errors = 8'd0;
      m_ready = 1'b1;
   endtask

   task automatic reset_dut();
      reset = 1'b1;
      idle_inputs();
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
      tick();
   endtask

   // Push one frame into the arbiter, checking each beat reaches the decoder.
   task automatic send_frame(input int ch, input logic [23:0] base, input int len);
      int n;
      for (int i = 0; i < len; i++) begin
         drive(ch, 1'b1, (i == 0), (i == len - 1), base + 24'(i));
         #1;
         n = 0;
         while (!rdy(ch) && n < 20) begin
            tick();
            n++;
         end
         chk("send_ready_timeout", {31'd0, (n < 20)}, 32'd1);
         chk("dec_data_in", {8'd0, dec_data_in}, {8'd0, base + 24'(i)});
         chk("dec_load", {31'd0, dec_load}, 32'd1);
         tick();
      end
      drive(ch, 1'b0, 1'b0, 1'b0, 24'd0);
   endtask

   // Play one decoded frame out of the decoder and check the returned stream.
   task automatic recv_frame(input int ch, input logic [23:0] base, input int len,
                             input logic [7:0] nerr);
      m_ready = 1'b1;
      for (int i = 0; i < len; i++) begin
         dec_valid_out = 1'b1;
         dec_sop_out = (i == 0);
         dec_eop_out = (i == len - 1);
         dec_data_out = base + 24'(i);
         dec_number_errors = (i == len - 1) ? nerr : 8'd0;
         #1;
         chk("m_valid", {31'd0, m_valid}, 32'd1);
         chk("m_chan", {31'd0, m_chan}, ch[31:0]);
         chk("m_data", {8'd0, m_data}, {8'd0, base + 24'(i)});
         tick();
      end
      dec_valid_out = 1'b0; dec_sop_out = 1'b0; dec_eop_out = 1'b0;
      dec_number_errors = 8'd0;
   endtask

   initial begin
      int w0, w1, frames, cur, bad, gi, cyc, ch;
      logic [3:0] gseq;

      // Reset state, with an orphan beat and decoder output present.
      reset = 1'b1;
      idle_inputs();
      s0_valid = 1'b1;
      dec_valid_out = 1'b1;
      @(posedge clk);
      #2;
      chk("rst_s0_ready", {31'd0, s0_ready}, 32'd0);
      chk("rst_dec_load", {31'd0, dec_load}, 32'd0);
      chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
      chk("rst_sink_ready", {31'd0, dec_sink_ready}, 32'd0);
      tick();
      chk("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
      chk("rst_err_tot0", {16'd0, err_tot0}, 32'd0);
      chk("rst_proto_err", {31'd0, proto_err}, 32'd0);
      idle_inputs();
      reset = 1'b0;
      tick();

      // Channel 0 only: three 8-word frames, error counts 2, 0, 5.
      send_frame(0, 24'h000100, 8);
      send_frame(0, 24'h000200, 8);
      send_frame(0, 24'h000300, 8);
      recv_frame(0, 24'h010100, 8, 8'd2);
      recv_frame(0, 24'h010200, 8, 8'd0);
      recv_frame(0, 24'h010300, 8, 8'd5);
      chk("ch0_err_tot0", {16'd0, err_tot0}, 32'd7);
      chk("ch0_err_tot1", {16'd0, err_tot1}, 32'd0);
      chk("ch0_proto_err", {31'd0, proto_err}, 32'd0);

      // Round robin: both channels hold sop from reset, 2-word frames.
      reset_dut();
      w0 = 0; w1 = 0; frames = 0; cur = -1; bad = 0; gi = 0; cyc = 0; gseq = 4'd0;
      while (frames < 4 && cyc < 60) begin
         drive(0, 1'b1, (w0 == 0), (w0 == 1), 24'h0A0000 + 24'(w0));
         drive(1, 1'b1, (w1 == 0), (w1 == 1), 24'h0B0000 + 24'(w1));
         #1;
         if (s0_ready && s1_ready) bad++;
         if (dec_load) begin
            ch = s1_ready ? 1 : 0;
            if (dec_data_in[23:16] != ((ch == 1) ? 8'h0B : 8'h0A)) bad++;
            if (dec_sop_in) begin
               cur = ch;
               if (gi < 4) gseq[gi] = ch[0];
               gi++;
            end else if (ch != cur) begin
               bad++;
            end
            if (dec_eop_in) frames++;
            if (ch == 0) w0 = (w0 + 1) % 2;
            else w1 = (w1 + 1) % 2;
         end
         tick();
         cyc++;
      end
      chk("rr_frames", frames[31:0], 32'd4);
      chk("rr_grant_order", {28'd0, gseq}, 32'b1010);
      chk("rr_interleave", bad[31:0], 32'd0);

      // Tag FIFO full: four single-beat frames with m_ready low block the fifth.
      reset_dut();
      m_ready = 1'b0;
      for (int f = 0; f < 4; f++) send_frame(0, 24'h000400 + 24'(f), 1);
      drive(0, 1'b1, 1'b1, 1'b1, 24'h000500);
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("full_s0_ready", {31'd0, s0_ready}, 32'd0);
         tick();
      end
      dec_valid_out = 1'b1; dec_sop_out = 1'b1; dec_eop_out = 1'b1;
      dec_data_out = 24'h000400;
      #1;
      chk("full_m_valid", {31'd0, m_valid}, 32'd1);
      chk("full_sink_ready", {31'd0, dec_sink_ready}, 32'd0);
      tick();
      m_ready = 1'b1;
      #1;
      chk("pop_sink_ready", {31'd0, dec_sink_ready}, 32'd1);
      tick();
      dec_valid_out = 1'b0; dec_sop_out = 1'b0; dec_eop_out = 1'b0;
      #1;
      chk("pop_grant_pending", {31'd0, s0_ready}, 32'd0);
      tick();
      chk("fifth_granted", {31'd0, s0_ready}, 32'd1);
      chk("fifth_load", {31'd0, dec_load}, 32'd1);
      tick();
      drive(0, 1'b0, 1'b0, 1'b0, 24'd0);

      // Saturation: 400 single-beat frames on channel 1, 200 errors each.
      reset_dut();
      for (int i = 0; i < 400; i++) begin
         drive(1, 1'b1, 1'b1, 1'b1, 24'(i));
         tick();
         tick();
         drive(1, 1'b0, 1'b0, 1'b0, 24'd0);
         dec_valid_out = 1'b1; dec_sop_out = 1'b1; dec_eop_out = 1'b1;
         dec_number_errors = 8'd200;
         tick();
         dec_valid_out = 1'b0; dec_sop_out = 1'b0; dec_eop_out = 1'b0;
         dec_number_errors = 8'd0;
         if (i == 326) chk("sat_before", {16'd0, err_tot1}, 32'd65400);
      end
      chk("sat_err_tot1", {16'd0, err_tot1}, 32'd65535);
      chk("sat_err_tot0", {16'd0, err_tot0}, 32'd0);

      // Orphans and protocol error.
      reset_dut();
      for (int k = 0; k < 3; k++) begin
         drive(1, 1'b1, 1'b0, 1'b0, 24'h000077);
         #1;
         chk("orph_s1_ready", {31'd0, s1_ready}, 32'd1);
         tick();
      end
      drive(1, 1'b0, 1'b0, 1'b0, 24'd0);
      #1;
      chk("orph_drop3", {24'd0, drop_cnt}, 32'd3);
      drive(0, 1'b1, 1'b0, 1'b0, 24'h000011);
      drive(1, 1'b1, 1'b0, 1'b0, 24'h000022);
      tick();
      drive(0, 1'b0, 1'b0, 1'b0, 24'd0);
      drive(1, 1'b0, 1'b0, 1'b0, 24'd0);
      chk("orph_drop5", {24'd0, drop_cnt}, 32'd5);
      dec_valid_out = 1'b1; dec_sop_out = 1'b1; dec_eop_out = 1'b1;
      m_ready = 1'b0;
      #1;
      chk("proto_m_valid", {31'd0, m_valid}, 32'd0);
      chk("proto_sink_ready", {31'd0, dec_sink_ready}, 32'd1);
      chk("proto_before", {31'd0, proto_err}, 32'd0);
      tick();
      chk("proto_err_set", {31'd0, proto_err}, 32'd1);
      dec_valid_out = 1'b0; dec_sop_out = 1'b0; dec_eop_out = 1'b0;
      m_ready = 1'b1;

      // Reset mid-frame on word 4 of 8, then a clean channel 0 frame.
      drive(0, 1'b1, 1'b1, 1'b0, 24'h000C00);
      tick();
      for (int i = 0; i < 4; i++) begin
         drive(0, 1'b1, (i == 0), 1'b0, 24'h000C00 + 24'(i));
         #1;
         chk("mid_s0_ready", {31'd0, s0_ready}, 32'd1);
         if (i < 3) tick();
      end
      reset = 1'b1;
      #1;
      chk("mid_rst_s0_ready", {31'd0, s0_ready}, 32'd0);
      chk("mid_rst_dec_load", {31'd0, dec_load}, 32'd0);
      chk("mid_rst_proto_err", {31'd0, proto_err}, 32'd0);
      chk("mid_rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
      @(posedge clk);
      #2 reset = 1'b0;
      idle_inputs();
      tick();
      send_frame(0, 24'h000D00, 8);
      recv_frame(0, 24'h020D00, 8, 8'd3);
      chk("post_rst_err_tot0", {16'd0, err_tot0}, 32'd3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
